// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port synchronous data memory between the processor
// and a game/peripheral port, with a bounded processor burst under contention.
module dmem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int P_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [31:0]       p_wdata,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [31:0]       p_rdata,
    input  logic              g_req,
    input  logic              g_wren,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [31:0]       g_wdata,
    output logic              g_gnt,
    output logic              g_rvalid,
    output logic [31:0]       g_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    typedef enum logic [1:0] {
        RSEL_NONE = 2'd0,
        RSEL_P    = 2'd1,
        RSEL_G    = 2'd2
    } rsel_e;

    localparam logic [3:0] BURST_MAX = 4'(P_BURST);

    logic [3:0]  burst_cnt_q, burst_cnt_d;
    rsel_e       rsel_q, rsel_d;
    logic [31:0] p_rdata_q, p_rdata_d;
    logic [31:0] g_rdata_q, g_rdata_d;
    logic        p_win, g_win, contested;

    // Grant decision and memory port mux; reset is active-low, so a high
    // level means normal operation and a low level forces everything idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        p_win     = 1'b0;
        g_win     = 1'b0;
        contested = p_req && g_req;
        if (reset) begin
            if (contested) begin
                p_win = (burst_cnt_q < BURST_MAX);
                g_win = !p_win;
            end else begin
                p_win = p_req;
                g_win = g_req;
            end
        end

        p_stall  = reset && p_req && !p_win;
        g_gnt    = g_win;
        mem_wren = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (p_win) begin
            mem_wren = p_wren;
            mem_addr = p_addr;
            mem_data = p_wdata;
        end else if (g_win) begin
            mem_wren = g_wren;
            mem_addr = g_addr;
            mem_data = g_wdata;
        end
    end

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (g_win) begin
            burst_cnt_d = '0;
        end else if (contested && p_win && (burst_cnt_q < BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end

        rsel_d = RSEL_NONE;
        if (p_win && !p_wren) begin
            rsel_d = RSEL_P;
        end else if (g_win && !g_wren) begin
            rsel_d = RSEL_G;
        end
    end

    // Read data passes straight from the RAM in the delivery cycle and is held
    // in a capture register afterwards, keeping grant-to-rvalid latency at one.
    always_comb begin
        p_rvalid  = (rsel_q == RSEL_P);
        g_rvalid  = (rsel_q == RSEL_G);
        p_rdata   = p_rvalid ? mem_q : p_rdata_q;
        g_rdata   = g_rvalid ? mem_q : g_rdata_q;
        p_rdata_d = p_rdata;
        g_rdata_d = g_rdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            burst_cnt_q <= '0;
            rsel_q      <= RSEL_NONE;
            p_rdata_q   <= '0;
            g_rdata_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            burst_cnt_q <= burst_cnt_d;
            rsel_q      <= rsel_d;
            p_rdata_q   <= p_rdata_d;
            g_rdata_q   <= g_rdata_d;
        end
    end

endmodule
